// File: rtl/ram_dp_be_if.sv
// Bus bundle for ram_dp_be: write port, read port, clear request and status.
interface ram_dp_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Handshake: the master may present a write (wena) and/or a read (rena)
    // every cycle; there is no ready signal. busy=1 means both ports are
    // ignored. A read accepted at edge n produces rdata with rvalid=1 for
    // exactly the cycle after edge n. clr is honoured only when busy=0.
    logic              clr;
    logic              busy;
    logic              wena;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wbe;
    logic              rena;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [0:0]        state;   // FSM state, exported for observation

    modport master (
        output clr, wena, waddr, wdata, wbe, rena, raddr,
        input  busy, rdata, rvalid, state
    );

    modport slave (
        input  clr, wena, waddr, wdata, wbe, rena, raddr,
        output busy, rdata, rvalid, state
    );
endinterface

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte enables, registered read with valid strobe,
// selectable read-during-write policy and a clear engine that zeroes every
// entry after reset or on request.
module ram_dp_be #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int RD_MODE = 0    // 0: read-first, 1: write-first bypass
) (
    input  logic          clk,
    input  logic          rst,
    ram_dp_be_if.slave    bus
);
    localparam int NB = DATA_W / 8;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              idle;
    logic              w_in;
    logic              r_in;
    logic              wr_go;
    logic              rd_go;
    logic              collide;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] rd_word;

    assign idle  = (state == S_IDLE);
    assign w_in  = ({1'b0, bus.waddr} < (ADDR_W+1)'(DEPTH));
    assign r_in  = ({1'b0, bus.raddr} < (ADDR_W+1)'(DEPTH));
    // A clr accepted at this edge starts the sweep, so user traffic on the
    // same edge is dropped to keep rvalid low for the whole busy window.
    assign wr_go = idle && !bus.clr && bus.wena && w_in;
    assign rd_go = idle && !bus.clr && bus.rena;
    assign collide = wr_go && r_in && (bus.raddr == bus.waddr);

    assign bus.busy  = !idle;
    assign bus.state = state;

    // Read word selection: out-of-range reads return zero; in write-first
    // mode a colliding write is merged byte by byte over the old word.
    always_comb begin
        old_word = '0;
        if (r_in) old_word = mem[bus.raddr];
        rd_word = old_word;
        if (RD_MODE == 1 && collide) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.wbe[k]) rd_word[8*k +: 8] = bus.wdata[8*k +: 8];
            end
        end
    end

    // Clear engine FSM: sweep entries 0..DEPTH-1, then serve the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else if (state == S_CLEAR) begin
            if (cnt == ADDR_W'(DEPTH - 1)) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (bus.clr) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end
    end

    // Storage update: sweep writes zero, otherwise byte-enabled user write.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[cnt] <= '0;
        end else if (wr_go) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.wbe[k]) mem[bus.waddr][8*k +: 8] <= bus.wdata[8*k +: 8];
            end
        end
    end

    // Registered read port: rdata holds between reads, rvalid pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= rd_go;
            if (rd_go) bus.rdata <= rd_word;
        end
    end
endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: three instances (read-first, write-first,
// DEPTH=20) driven by the same stimulus.
module tb_ram_dp_be;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        rena;
    logic [4:0]  raddr;

    int checks = 0;
    int failures = 0;
    int n0, n1, n2;
    int v0, v1, v2;

    ram_dp_be_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    ram_dp_be_if #(.DATA_W(32), .ADDR_W(5)) b1 ();
    ram_dp_be_if #(.DATA_W(32), .ADDR_W(5)) b2 ();

    assign b0.clr = clr;     assign b1.clr = clr;     assign b2.clr = clr;
    assign b0.wena = wena;   assign b1.wena = wena;   assign b2.wena = wena;
    assign b0.waddr = waddr; assign b1.waddr = waddr; assign b2.waddr = waddr;
    assign b0.wdata = wdata; assign b1.wdata = wdata; assign b2.wdata = wdata;
    assign b0.wbe = wbe;     assign b1.wbe = wbe;     assign b2.wbe = wbe;
    assign b0.rena = rena;   assign b1.rena = rena;   assign b2.rena = rena;
    assign b0.raddr = raddr; assign b1.raddr = raddr; assign b2.raddr = raddr;

    ram_dp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    ram_dp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    ram_dp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .RD_MODE(0)) u2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wena = 1'b1; waddr = a; wdata = d; wbe = be;
        tick();
        wena = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        rena = 1'b1; raddr = a;
        tick();
        rena = 1'b0;
    endtask

    // Edges after rst release until busy drops on each instance (bounded).
    task automatic wait_sweep(output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (!b0.busy && c0 == 0) c0 = i;
            if (!b1.busy && c1 == 0) c1 = i;
            if (!b2.busy && c2 == 0) c2 = i;
        end
    endtask

    // Back-to-back reads of every address, all expected to be zero.
    task automatic read_all_zero(input string tag);
        rena = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr = 5'(a);
            tick();
            chk({tag, "_u0_rdata"}, b0.rdata, 32'h0);
            chk({tag, "_u0_rvalid"}, 32'(b0.rvalid), 32'h1);
            chk({tag, "_u1_rdata"}, b1.rdata, 32'h0);
            chk({tag, "_u2_rdata"}, b2.rdata, 32'h0);
            chk({tag, "_u2_rvalid"}, 32'(b2.rvalid), 32'h1);
        end
        rena = 1'b0;
        tick();
        chk({tag, "_rvalid_off"}, 32'(b0.rvalid), 32'h0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wena = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        rena = 1'b0; raddr = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(b0.busy), 32'h1);
        chk("rst_state", 32'(b0.state), 32'h1);
        chk("rst_rdata", b0.rdata, 32'h0);
        chk("rst_rvalid", 32'(b0.rvalid), 32'h0);

        // Power-up sweep length
        rst = 1'b0;
        wait_sweep(n0, n1, n2);
        chk("sweep_len_u0", 32'(n0), 32'd32);
        chk("sweep_len_u1", 32'(n1), 32'd32);
        chk("sweep_len_u2", 32'(n2), 32'd20);
        chk("idle_state", 32'(b0.state), 32'h0);
        read_all_zero("init");

        // Full write then read, one-cycle rvalid pulse
        wr(5'd3, 32'hDEADBEEF, 4'b1111);
        rd(5'd3);
        chk("rd3_data", b0.rdata, 32'hDEADBEEF);
        chk("rd3_valid", 32'(b0.rvalid), 32'h1);
        tick();
        chk("rd3_valid_drop", 32'(b0.rvalid), 32'h0);
        chk("rd3_hold", b0.rdata, 32'hDEADBEEF);

        // Partial byte write
        wr(5'd3, 32'h11223344, 4'b0101);
        rd(5'd3);
        chk("be0101", b0.rdata, 32'hDE22BE44);

        // wbe=0 is a no-op
        wr(5'd3, 32'h00000000, 4'b0000);
        rd(5'd3);
        chk("be0000", b0.rdata, 32'hDE22BE44);

        // Same-edge collision
        wr(5'd7, 32'h12345678, 4'b1111);
        wena = 1'b1; waddr = 5'd7; wdata = 32'hAAAAAAAA; wbe = 4'b0011;
        rena = 1'b1; raddr = 5'd7;
        tick();
        wena = 1'b0; rena = 1'b0;
        chk("coll_rdfirst", b0.rdata, 32'h12345678);
        chk("coll_wrfirst", b1.rdata, 32'h1234AAAA);
        chk("coll_rdfirst_u2", b2.rdata, 32'h12345678);
        rd(5'd7);
        chk("coll_after_u0", b0.rdata, 32'h1234AAAA);
        chk("coll_after_u1", b1.rdata, 32'h1234AAAA);

        // Out-of-range on DEPTH=20, in range on DEPTH=32
        wr(5'd25, 32'hFFFFFFFF, 4'b1111);
        rd(5'd25);
        chk("oor_u2_data", b2.rdata, 32'h0);
        chk("oor_u2_valid", 32'(b2.rvalid), 32'h1);
        chk("inr_u0_data", b0.rdata, 32'hFFFFFFFF);

        // Clear request with traffic during busy
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wena = 1'b1; waddr = 5'd5; wdata = 32'h55555555; wbe = 4'b1111;
        rena = 1'b1; raddr = 5'd3;
        n0 = 0; n2 = 0; v0 = 0; v1 = 0; v2 = 0;
        for (int i = 0; i < 40; i++) begin
            if (b0.busy) begin n0++; if (b0.rvalid) v0++; end
            if (b1.busy && b1.rvalid) v1++;
            if (b2.busy) begin n2++; if (b2.rvalid) v2++; end
            if (i == 17) begin wena = 1'b0; rena = 1'b0; end
            tick();
        end
        chk("clr_busy_u0", 32'(n0), 32'd32);
        chk("clr_busy_u2", 32'(n2), 32'd20);
        chk("clr_rvalid_u0", 32'(v0), 32'd0);
        chk("clr_rvalid_u1", 32'(v1), 32'd0);
        chk("clr_rvalid_u2", 32'(v2), 32'd0);
        chk("clr_rdata_hold", b0.rdata, 32'hFFFFFFFF);
        read_all_zero("clr");

        // Async reset in the middle of a read result
        wr(5'd9, 32'hCAFEF00D, 4'b1111);
        rd(5'd9);
        chk("pre_rst_data", b0.rdata, 32'hCAFEF00D);
        rst = 1'b1;
        #1;
        chk("async_rdata", b0.rdata, 32'h0);
        chk("async_rvalid", 32'(b0.rvalid), 32'h0);
        chk("async_busy", 32'(b0.busy), 32'h1);
        tick();
        rst = 1'b0;

        // Reset again mid-sweep: the sweep restarts from zero
        repeat (10) tick();
        chk("mid_sweep_busy", 32'(b2.busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_sweep(n0, n1, n2);
        chk("restart_len_u0", 32'(n0), 32'd32);
        chk("restart_len_u2", 32'(n2), 32'd20);
        rd(5'd9);
        chk("restart_zero", b0.rdata, 32'h0);
        chk("restart_valid", 32'(b0.rvalid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
Parametrised simple-dual-port RAM. One write port with per-byte enables and one independent read port. Reads are synchronous, with a valid strobe and selectable read-during-write policy. A built-in clear engine zeroes every entry after reset or on request. Drop-in storage for register files, data memories and scratch buffers, replacing the fixed 32x32 single-port RAM.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 5, address width.
DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_W.
RD_MODE, 0, collision policy: 0 = read-first (old data), 1 = write-first (new data bypassed).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
clr  in  1  request to zero all entries; sampled in IDLE only.
busy  out  1  high while the clear engine runs; both ports are ignored.
wena  in  1  write enable.
waddr  in  ADDR_W  write address.
wdata  in  DATA_W  write data.
wbe  in  DATA_W/8  byte enables; bit k covers wdata[8k+7:8k].
rena  in  1  read enable.
raddr  in  ADDR_W  read address.
rdata  out  DATA_W  registered read data.
rvalid  out  1  one-cycle strobe marking new rdata.

Behaviour:
- Reset (async, rst=1):
  - state=CLEAR, clear counter=0, busy=1, rdata=0, rvalid=0.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM states: CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to entry cnt, then cnt++. After writing DEPTH-1, go to IDLE next edge.
  - A full sweep takes exactly DEPTH cycles after rst deasserts; busy falls in the cycle the FSM enters IDLE.
  - IDLE to CLEAR on clr=1 at an edge: cnt=0, busy=1 from the next cycle.
  - clr while in CLEAR is ignored; the sweep does not restart.
- While busy=1:
  - wena and rena are ignored; no user write occurs.
  - rvalid stays 0 and rdata holds its value.
- Write (IDLE, wena=1, waddr<DEPTH): at the edge, bytes with wbe[k]=1 are updated; other bytes are unchanged. wbe=0 is a no-op.
- Read (IDLE, rena=1): latency 1.
  - Edge n samples raddr. After edge n, rdata=mem[raddr] and rvalid=1 for exactly one cycle.
  - With rena=0, rvalid=0 and rdata holds its last value; it is never driven to Z.
  - Back-to-back reads give one result per cycle.
- Out of range (DEPTH < 2**ADDR_W): writes to addr>=DEPTH are dropped. Reads of addr>=DEPTH return 0 with rvalid=1.
- Collision (rena & wena & raddr==waddr, in range, same edge):
  - RD_MODE=0: rdata = pre-write word.
  - RD_MODE=1: rdata = per-byte merge, wdata where wbe=1, else the old byte.
  - The array is always updated.
- rst asserted mid-sweep or mid-access: immediate return to reset values. The sweep restarts from 0 after rst falls; any in-flight read result is discarded.
- Storage is a plain reg array; synthesisable as block or distributed RAM. Only the bypass mux is extra logic.

Test Plan:
- rst pulse, DEPTH=32, then idle → busy=1 for 32 cycles then 0. Reading all addresses gives 0 with one rvalid per read.
- Write 0xDEADBEEF @3 (wbe=1111); next cycle rena @3 → rdata=0xDEADBEEF one cycle after rena, rvalid pulse width 1.
- Write 0x11223344 @3 with wbe=0101 over 0xDEADBEEF → read @3 returns 0xDE22BE44.
- Same-edge write 0xAAAAAAAA wbe=0011 and read @7, old 0x12345678:
  - RD_MODE=0 → 0x12345678.
  - RD_MODE=1 → 0x1234AAAA.
  - Either mode: a later read → 0x1234AAAA.
- clr pulse after filling memory; wena/rena driven during busy → no write and no rvalid during the 32 busy cycles; all entries read 0 afterwards.
- DEPTH=20, ADDR_W=5: write 0xFFFFFFFF @25, read @25 → 0, rvalid=1. Assert rst at sweep cycle 10 → sweep restarts, busy high for 20 cycles after release.
